// File: rtl/counter_seq_checker.sv
// Sequence checker for up/down/LFSR counter streams: locks onto the incoming word
// sequence, then flags and counts every out-of-sequence word while tracking.
module counter_seq_checker #(
    parameter int unsigned  N        = 8,
    parameter int unsigned  MODE     = 0,
    parameter logic [N-1:0] TAPS     = 'hB8,
    parameter int unsigned  LOCK_CNT = 4,
    parameter int unsigned  LOSS_CNT = 4,
    parameter int unsigned  ERR_W    = 16
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_in_valid,
    input  logic [N-1:0]     i_in_count,
    input  logic             i_clear_err,
    output logic             o_locked,
    output logic             o_err_pulse,
    output logic [ERR_W-1:0] o_err_cnt,
    output logic [N-1:0]     o_expected
);

    localparam int unsigned RUN_MAX = (LOCK_CNT > LOSS_CNT) ? LOCK_CNT : LOSS_CNT;
    localparam int unsigned RUN_W   = $clog2(RUN_MAX + 1);

    typedef enum logic [1:0] {StSeek, StLock, StTrack} state_e;

    state_e           r_state, w_state_nxt;
    logic [N-1:0]     r_expected, w_expected_nxt;
    logic [RUN_W-1:0] r_match_run, w_match_run_nxt;
    logic [RUN_W-1:0] r_miss_run, w_miss_run_nxt;
    logic             r_err_pulse, w_err_pulse_nxt;
    logic [ERR_W-1:0] r_err_cnt, w_err_cnt_nxt;

    logic [N-1:0]     w_pred;
    logic             w_match;
    logic [RUN_W-1:0] w_match_inc, w_miss_inc;
    logic             w_lock_hit, w_loss_hit;

    function automatic logic [N-1:0] f_pred(input logic [N-1:0] r);
        if (MODE == 0) begin
            return r + N'(1);
        end else if (MODE == 1) begin
            return r - N'(1);
        end else begin
            return {r[N-2:0], ^(r & TAPS)};
        end
    endfunction

    // An LFSR never produces all-zeros, so a zero word is always out of sequence.
    assign w_pred      = f_pred(r_expected);
    assign w_match     = (i_in_count == w_pred) && !((MODE == 2) && (i_in_count == '0));
    assign w_match_inc = r_match_run + RUN_W'(1);
    assign w_miss_inc  = r_miss_run + RUN_W'(1);
    assign w_lock_hit  = (w_match_inc == RUN_W'(LOCK_CNT));
    assign w_loss_hit  = (w_miss_inc == RUN_W'(LOSS_CNT));

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state     <= StSeek;
            r_expected  <= '0;
            r_match_run <= '0;
            r_miss_run  <= '0;
            r_err_pulse <= 1'b0;
            r_err_cnt   <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_expected  <= w_expected_nxt;
            r_match_run <= w_match_run_nxt;
            r_miss_run  <= w_miss_run_nxt;
            r_err_pulse <= w_err_pulse_nxt;
            r_err_cnt   <= w_err_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        if (i_in_valid) begin
            case (r_state)
                StSeek:  w_state_nxt = StLock;
                StLock:  if (w_match && w_lock_hit) w_state_nxt = StTrack;
                StTrack: if (!w_match && w_loss_hit) w_state_nxt = StSeek;
                default: w_state_nxt = StSeek;
            endcase
        end
    end

    always_comb begin
        w_expected_nxt  = r_expected;
        w_match_run_nxt = r_match_run;
        w_miss_run_nxt  = r_miss_run;
        w_err_pulse_nxt = 1'b0;
        w_err_cnt_nxt   = r_err_cnt;
        if (i_in_valid) begin
            case (r_state)
                StSeek: begin
                    w_expected_nxt  = i_in_count;
                    w_match_run_nxt = '0;
                end
                StLock: begin
                    w_expected_nxt = i_in_count;
                    if (w_match) begin
                        w_match_run_nxt = w_lock_hit ? '0 : w_match_inc;
                        if (w_lock_hit) w_miss_run_nxt = '0;
                    end else begin
                        w_match_run_nxt = '0;
                    end
                end
                StTrack: begin
                    if (w_match) begin
                        w_expected_nxt = i_in_count;
                        w_miss_run_nxt = '0;
                    end else begin
                        // Flywheel on the prediction so one bad word costs exactly one error.
                        w_expected_nxt  = w_pred;
                        w_err_pulse_nxt = 1'b1;
                        if (r_err_cnt != '1) w_err_cnt_nxt = r_err_cnt + ERR_W'(1);
                        w_miss_run_nxt  = w_loss_hit ? '0 : w_miss_inc;
                    end
                end
                default: ;
            endcase
        end
        if (i_clear_err) w_err_cnt_nxt = '0;
    end

    assign o_locked    = (r_state == StTrack);
    assign o_err_pulse = r_err_pulse;
    assign o_err_cnt   = r_err_cnt;
    assign o_expected  = r_expected;

endmodule
